per2axi_mo: RTL and testbench

//  Multiple-outstanding peripheral-to-AXI4 bridge, successor to the single-ID cluster bridge.
//  - Converts 32-bit peripheral-interconnect requests into single-beat AXI4 transactions.
//  - Tracks up to MAX_OUTSTANDING in-flight transactions. AXI ID = tracking-slot index.
//  - Steers 32-bit lanes onto a 32/64/128-bit AXI data bus.
//  - Returns out-of-order R/B responses to the originating per ID.

---
 rtl/per2axi_mo_pkg.sv | 91 +++++++++
 rtl/per2axi_mo_slot_table.sv | 68 ++++++
 rtl/per2axi_mo.sv | 187 ++++++++++++++++++
 tb/tb_per2axi_mo.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/per2axi_mo_pkg.sv
// Shared constants, slot-entry layout and default AXI4 channel structs for the
// multiple-outstanding peripheral-to-AXI4 bridge.
package per2axi_mo_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B     = 3'd2;

  // Slot fields are sized for the widest supported configuration; the top
  // narrows them back to its own parameters.
  localparam int unsigned SLOT_ID_W   = 16;
  localparam int unsigned SLOT_LANE_W = 2;

  typedef struct packed {
    logic [SLOT_ID_W-1:0]   per_id;
    logic                   we;
    logic [SLOT_LANE_W-1:0] lane;
  } slot_entry_t;

  // Index of the 32-bit lane an address falls into on a dw-bit bus.
  function automatic logic [SLOT_LANE_W-1:0] lane_of(input logic [63:0] addr,
                                                     input int unsigned dw);
    int unsigned lane_bits;
    lane_bits = (dw > 32) ? $clog2(dw / 32) : 0;
    return SLOT_LANE_W'((addr >> 2) & ((64'd1 << lane_bits) - 64'd1));
  endfunction

  localparam int unsigned DEF_ID_W   = 3;
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 64;

  typedef struct packed {
    logic [DEF_ID_W-1:0]   id;
    logic [DEF_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [0:0]            user;
  } default_ax_chan_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0]   data;
    logic [DEF_DATA_W/8-1:0] strb;
    logic                    last;
    logic [0:0]              user;
  } default_w_chan_t;

  typedef struct packed {
    logic [DEF_ID_W-1:0]   id;
    logic [DEF_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
    logic [0:0]            user;
  } default_r_chan_t;

  typedef struct packed {
    logic [DEF_ID_W-1:0] id;
    logic [1:0]          resp;
    logic [0:0]          user;
  } default_b_chan_t;

  typedef struct packed {
    default_ax_chan_t aw;
    logic             aw_valid;
    default_w_chan_t  w;
    logic             w_valid;
    default_ax_chan_t ar;
    logic             ar_valid;
    logic             r_ready;
    logic             b_ready;
  } default_axi_req_t;

  typedef struct packed {
    logic            aw_ready;
    logic            w_ready;
    logic            ar_ready;
    default_r_chan_t r;
    logic            r_valid;
    default_b_chan_t b;
    logic            b_valid;
  } default_axi_rsp_t;

endpackage

// File: rtl/per2axi_mo_slot_table.sv
// Tracking table for in-flight transactions: lowest-free allocation, release by
// AXI ID, and lookup of the originating requester for a returning response.
module per2axi_mo_slot_table
  import per2axi_mo_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             alloc_i,
  input  slot_entry_t      alloc_entry_i,
  output logic [IDX_W-1:0] alloc_idx_o,
  output logic             full_o,
  input  logic             free_i,
  input  logic [IDX_W-1:0] free_idx_i,
  input  logic [IDX_W-1:0] lookup_idx_i,
  output logic             lookup_valid_o,
  output slot_entry_t      lookup_entry_o,
  output logic             any_valid_o
);

  logic [DEPTH-1:0] valid_q, valid_d;
  slot_entry_t      entry_q [DEPTH];
  slot_entry_t      entry_d [DEPTH];

  // NOTE: every signal written in always_comb is given a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    alloc_idx_o = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx_o = IDX_W'(i);
    end
  end

  assign full_o      = &valid_q;
  assign any_valid_o = |valid_q;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (free_i) valid_d[free_idx_i] = 1'b0;
    if (alloc_i) begin
      valid_d[alloc_idx_o] = 1'b1;
      entry_d[alloc_idx_o] = alloc_entry_i;
    end
  end

  always_comb begin
    lookup_valid_o = 1'b0;
    lookup_entry_o = '0;
    if (int'(lookup_idx_i) < int'(DEPTH)) begin
      lookup_valid_o = valid_q[lookup_idx_i];
      lookup_entry_o = entry_q[lookup_idx_i];
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values; blocking here races with other processes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) valid_q <= '0;
    else         valid_q <= valid_d;
  end

  // NOTE: the payload array has no reset; it is only ever read when the matching valid bit is set.
  always_ff @(posedge clk_i) begin
    entry_q <= entry_d;
  end

endmodule

// File: rtl/per2axi_mo.sv
// Multiple-outstanding peripheral-to-AXI4 bridge: single-beat AXI transactions,
// AXI ID = tracking slot. Define PER2AXI_MO_ERR_RESP_EN to report SLVERR/DECERR on r_opc.
module per2axi_mo
  import per2axi_mo_pkg::*;
#(
  parameter int unsigned PER_ADDR_WIDTH  = 32,
  parameter int unsigned PER_ID_WIDTH    = 5,
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter int unsigned AXI_DATA_WIDTH  = 64,
  parameter int unsigned AXI_ID_WIDTH    = 3,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter type         axi_req_t       = per2axi_mo_pkg::default_axi_req_t,
  parameter type         axi_rsp_t       = per2axi_mo_pkg::default_axi_rsp_t
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      per_slave_req_i,
  input  logic [PER_ADDR_WIDTH-1:0] per_slave_add_i,
  input  logic                      per_slave_we_i,
  input  logic [31:0]               per_slave_wdata_i,
  input  logic [3:0]                per_slave_be_i,
  input  logic [PER_ID_WIDTH-1:0]   per_slave_id_i,
  output logic                      per_slave_gnt_o,
  output logic                      per_slave_r_valid_o,
  output logic                      per_slave_r_opc_o,
  output logic [PER_ID_WIDTH-1:0]   per_slave_r_id_o,
  output logic [31:0]               per_slave_r_rdata_o,
  output axi_req_t                  axi_master_req_o,
  input  axi_rsp_t                  axi_master_rsp_i,
  output logic                      busy_o
);

  localparam int unsigned IDX_W     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned NUM_LANES = AXI_DATA_WIDTH / 32;
  localparam int unsigned STRB_W    = AXI_DATA_WIDTH / 8;

  axi_req_t                req_q, req_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_opc_q, rsp_opc_d;
  logic [PER_ID_WIDTH-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]             rsp_rdata_q, rsp_rdata_d;

  logic                    grant;
  logic                    tbl_full, tbl_any, tbl_hit_valid;
  logic [IDX_W-1:0]        alloc_idx, lookup_idx;
  slot_entry_t             alloc_entry, tbl_entry;
  logic                    r_accept, b_accept, rsp_accept, rsp_hit;
  logic [AXI_ID_WIDTH-1:0] rsp_axi_id;
  logic [1:0]              rsp_resp;
  logic [SLOT_LANE_W-1:0]  lane;

  // A write needs both AW and W holding registers empty; a read only needs AR.
  assign grant = per_slave_req_i & ~tbl_full &
                 (per_slave_we_i ? (~req_q.aw_valid & ~req_q.w_valid) : ~req_q.ar_valid);
  assign lane  = lane_of(64'(per_slave_add_i), AXI_DATA_WIDTH);

  always_comb begin
    alloc_entry        = '0;
    alloc_entry.per_id = SLOT_ID_W'(per_slave_id_i);
    alloc_entry.we     = per_slave_we_i;
    alloc_entry.lane   = lane;
  end

  per2axi_mo_slot_table #(
    .DEPTH (MAX_OUTSTANDING),
    .IDX_W (IDX_W)
  ) u_slot_table (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .alloc_i        (grant),
    .alloc_entry_i  (alloc_entry),
    .alloc_idx_o    (alloc_idx),
    .full_o         (tbl_full),
    .free_i         (rsp_accept & rsp_hit),
    .free_idx_i     (lookup_idx),
    .lookup_idx_i   (lookup_idx),
    .lookup_valid_o (tbl_hit_valid),
    .lookup_entry_o (tbl_entry),
    .any_valid_o    (tbl_any)
  );

  always_comb begin
    req_d = req_q;
    if (axi_master_rsp_i.aw_ready) req_d.aw_valid = 1'b0;
    if (axi_master_rsp_i.w_ready)  req_d.w_valid  = 1'b0;
    if (axi_master_rsp_i.ar_ready) req_d.ar_valid = 1'b0;
    if (grant && per_slave_we_i) begin
      req_d.aw_valid  = 1'b1;
      req_d.aw.id     = AXI_ID_WIDTH'(alloc_idx);
      req_d.aw.addr   = AXI_ADDR_WIDTH'(per_slave_add_i);
      req_d.aw.len    = '0;
      req_d.aw.size   = AXI_SIZE_4B;
      req_d.aw.burst  = AXI_BURST_INCR;
      req_d.aw.lock   = 1'b0;
      req_d.aw.cache  = '0;
      req_d.aw.prot   = '0;
      req_d.aw.qos    = '0;
      req_d.aw.region = '0;
      req_d.aw.user   = '0;
      req_d.w_valid   = 1'b1;
      req_d.w.data    = {NUM_LANES{per_slave_wdata_i}};
      req_d.w.strb    = STRB_W'(per_slave_be_i) << (4 * int'(lane));
      req_d.w.last    = 1'b1;
      req_d.w.user    = '0;
    end else if (grant) begin
      req_d.ar_valid  = 1'b1;
      req_d.ar.id     = AXI_ID_WIDTH'(alloc_idx);
      req_d.ar.addr   = AXI_ADDR_WIDTH'(per_slave_add_i);
      req_d.ar.len    = '0;
      req_d.ar.size   = AXI_SIZE_4B;
      req_d.ar.burst  = AXI_BURST_INCR;
      req_d.ar.lock   = 1'b0;
      req_d.ar.cache  = '0;
      req_d.ar.prot   = '0;
      req_d.ar.qos    = '0;
      req_d.ar.region = '0;
      req_d.ar.user   = '0;
    end
  end

  // R wins over B; the losing B simply stays valid until the next cycle.
  always_comb begin
    r_accept   = axi_master_rsp_i.r_valid;
    b_accept   = axi_master_rsp_i.b_valid & ~axi_master_rsp_i.r_valid;
    rsp_accept = r_accept | b_accept;
    rsp_axi_id = r_accept ? axi_master_rsp_i.r.id   : axi_master_rsp_i.b.id;
    rsp_resp   = r_accept ? axi_master_rsp_i.r.resp : axi_master_rsp_i.b.resp;
    lookup_idx = IDX_W'(rsp_axi_id);
    rsp_hit    = (int'(rsp_axi_id) < int'(MAX_OUTSTANDING)) & tbl_hit_valid;
  end

  always_comb begin
    rsp_valid_d = rsp_accept & rsp_hit;
    rsp_id_d    = '0;
    rsp_rdata_d = '0;
    rsp_opc_d   = 1'b0;
    if (rsp_valid_d) begin
      rsp_id_d = PER_ID_WIDTH'(tbl_entry.per_id);
      if (r_accept) rsp_rdata_d = axi_master_rsp_i.r.data[32*int'(tbl_entry.lane) +: 32];
`ifdef PER2AXI_MO_ERR_RESP_EN
      rsp_opc_d = (rsp_resp != AXI_RESP_OKAY);
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_opc_q   <= 1'b0;
      rsp_id_q    <= '0;
      rsp_rdata_q <= '0;
    end else begin
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_opc_q   <= rsp_opc_d;
      rsp_id_q    <= rsp_id_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    axi_master_req_o         = req_q;
    axi_master_req_o.r_ready = axi_master_rsp_i.r_valid;
    axi_master_req_o.b_ready = b_accept;
  end

  assign per_slave_gnt_o     = grant;
  assign per_slave_r_valid_o = rsp_valid_q;
  assign per_slave_r_opc_o   = rsp_opc_q;
  assign per_slave_r_id_o    = rsp_id_q;
  assign per_slave_r_rdata_o = rsp_rdata_q;
  assign busy_o              = tbl_any | req_q.aw_valid | req_q.w_valid | req_q.ar_valid;

  // Fields that carry no meaning for single-beat 32-bit traffic.
  logic unused_bits;
  assign unused_bits = ^{axi_master_rsp_i.r.last, axi_master_rsp_i.r.user,
                         axi_master_rsp_i.b.user, tbl_entry, rsp_resp,
                         req_q.r_ready, req_q.b_ready};

`ifndef SYNTHESIS
  // A response must always map to a live slot; a stray ID is accepted and dropped.
  rsp_id_hits_live_slot: assert property (
    @(posedge clk_i) disable iff (!rst_ni) rsp_accept |-> rsp_hit);
`endif

endmodule

// File: tb/tb_per2axi_mo.sv
// Directed self-checking bench for per2axi_mo (default parameters, DW = 64).
module tb_per2axi_mo;
  import per2axi_mo_pkg::*;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             per_req = 1'b0;
  logic [31:0]      per_add = '0;
  logic             per_we = 1'b0;
  logic [31:0]      per_wdata = '0;
  logic [3:0]       per_be = '0;
  logic [4:0]       per_id = '0;
  logic             gnt, r_valid, r_opc;
  logic [4:0]       r_id;
  logic [31:0]      r_rdata;
  logic             busy;
  default_axi_req_t axi_req;
  default_axi_rsp_t axi_rsp = '0;

  int total = 0;
  int bad   = 0;

`ifdef PER2AXI_MO_ERR_RESP_EN
  localparam logic SLVERR_OPC = 1'b1;
`else
  localparam logic SLVERR_OPC = 1'b0;
`endif

  per2axi_mo dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .per_slave_req_i     (per_req),
    .per_slave_add_i     (per_add),
    .per_slave_we_i      (per_we),
    .per_slave_wdata_i   (per_wdata),
    .per_slave_be_i      (per_be),
    .per_slave_id_i      (per_id),
    .per_slave_gnt_o     (gnt),
    .per_slave_r_valid_o (r_valid),
    .per_slave_r_opc_o   (r_opc),
    .per_slave_r_id_o    (r_id),
    .per_slave_r_rdata_o (r_rdata),
    .axi_master_req_o    (axi_req),
    .axi_master_rsp_i    (axi_rsp),
    .busy_o              (busy)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] add, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [4:0] id);
    per_req = 1'b1; per_we = we; per_add = add; per_wdata = wdata; per_be = be; per_id = id;
  endtask

  task automatic drop_req();
    per_req = 1'b0; per_we = 1'b0; per_add = '0; per_wdata = '0; per_be = '0; per_id = '0;
  endtask

  task automatic send_r(input logic [2:0] id, input logic [63:0] data, input logic [1:0] resp);
    axi_rsp.r_valid = 1'b1; axi_rsp.r.id = id; axi_rsp.r.data = data;
    axi_rsp.r.resp = resp; axi_rsp.r.last = 1'b1;
  endtask

  task automatic send_b(input logic [2:0] id, input logic [1:0] resp);
    axi_rsp.b_valid = 1'b1; axi_rsp.b.id = id; axi_rsp.b.resp = resp;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    cyc(); cyc();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt: got %b want 0", gnt); end
    total++; if (r_valid !== 1'b0) begin bad++; $display("FAIL rst_r_valid: got %b want 0", r_valid); end
    total++; if (r_opc !== 1'b0) begin bad++; $display("FAIL rst_opc: got %b want 0", r_opc); end
    total++; if ({axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid} !== 3'b000) begin
      bad++; $display("FAIL rst_axi_valids: got %b want 000", {axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid}); end
    total++; if ({axi_req.r_ready, axi_req.b_ready} !== 2'b00) begin
      bad++; $display("FAIL rst_readies: got %b want 00", {axi_req.r_ready, axi_req.b_ready}); end
    rst_ni = 1'b1;
    cyc();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_read();
    drive_req(1'b0, 32'h1000_0004, '0, 4'hf, 5'd3); #1;
    total++; if (gnt !== 1'b1) begin bad++; $display("FAIL rd_gnt: got %b want 1", gnt); end
    cyc(); drop_req();
    total++; if (axi_req.ar_valid !== 1'b1) begin bad++; $display("FAIL rd_ar_valid: got %b want 1", axi_req.ar_valid); end
    total++; if (axi_req.ar.addr !== 32'h1000_0004) begin bad++; $display("FAIL rd_ar_addr: got %h want 10000004", axi_req.ar.addr); end
    total++; if ({axi_req.ar.id, axi_req.ar.size, axi_req.ar.len, axi_req.ar.burst} !== {3'd0, 3'd2, 8'd0, 2'b01}) begin
      bad++; $display("FAIL rd_ar_fields: got id=%0d size=%0d len=%0d burst=%0d want 0 2 0 1",
                      axi_req.ar.id, axi_req.ar.size, axi_req.ar.len, axi_req.ar.burst); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rd_busy: got %b want 1", busy); end
    axi_rsp.ar_ready = 1'b1;
    cyc(); axi_rsp.ar_ready = 1'b0;
    total++; if (axi_req.ar_valid !== 1'b0) begin bad++; $display("FAIL rd_ar_clear: got %b want 0", axi_req.ar_valid); end
    send_r(3'd0, 64'hDEAD_BEEF_0000_0000, AXI_RESP_OKAY); #1;
    total++; if (axi_req.r_ready !== 1'b1) begin bad++; $display("FAIL rd_r_ready: got %b want 1", axi_req.r_ready); end
    total++; if (r_valid !== 1'b0) begin bad++; $display("FAIL rd_r_valid_early: got %b want 0", r_valid); end
    cyc(); axi_rsp.r_valid = 1'b0;
    total++; if (r_valid !== 1'b1) begin bad++; $display("FAIL rd_r_valid: got %b want 1", r_valid); end
    total++; if (r_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_rdata: got %h want deadbeef", r_rdata); end
    total++; if (r_id !== 5'd3) begin bad++; $display("FAIL rd_r_id: got %0d want 3", r_id); end
    total++; if (r_opc !== 1'b0) begin bad++; $display("FAIL rd_opc: got %b want 0", r_opc); end
    cyc();
    total++; if (r_valid !== 1'b0) begin bad++; $display("FAIL rd_pulse: got %b want 0", r_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_write();
    drive_req(1'b1, 32'h2000_0004, 32'h1234_5678, 4'b0011, 5'd5); #1;
    total++; if (gnt !== 1'b1) begin bad++; $display("FAIL wr_gnt: got %b want 1", gnt); end
    cyc(); drop_req();
    total++; if ({axi_req.aw_valid, axi_req.w_valid} !== 2'b11) begin
      bad++; $display("FAIL wr_valids: got %b want 11", {axi_req.aw_valid, axi_req.w_valid}); end
    total++; if (axi_req.aw.addr !== 32'h2000_0004 || axi_req.aw.id !== 3'd0) begin
      bad++; $display("FAIL wr_aw: got addr=%h id=%0d want 20000004 0", axi_req.aw.addr, axi_req.aw.id); end
    total++; if (axi_req.w.data !== 64'h1234_5678_1234_5678) begin bad++; $display("FAIL wr_wdata: got %h want 1234567812345678", axi_req.w.data); end
    total++; if (axi_req.w.strb !== 8'h30) begin bad++; $display("FAIL wr_strb: got %h want 30", axi_req.w.strb); end
    total++; if (axi_req.w.last !== 1'b1) begin bad++; $display("FAIL wr_last: got %b want 1", axi_req.w.last); end
    axi_rsp.aw_ready = 1'b1;
    cyc(); axi_rsp.aw_ready = 1'b0;
    total++; if ({axi_req.aw_valid, axi_req.w_valid} !== 2'b01) begin
      bad++; $display("FAIL wr_indep_clear: got %b want 01", {axi_req.aw_valid, axi_req.w_valid}); end
    drive_req(1'b1, 32'h2000_0010, 32'h0, 4'hf, 5'd6); #1;
    total++; if (gnt !== 1'b0) begin bad++; $display("FAIL wr_block_gnt: got %b want 0", gnt); end
    per_we = 1'b0; #1;
    total++; if (gnt !== 1'b1) begin bad++; $display("FAIL wr_read_ok_gnt: got %b want 1", gnt); end
    drop_req();
    axi_rsp.w_ready = 1'b1;
    cyc(); axi_rsp.w_ready = 1'b0;
    total++; if (axi_req.w_valid !== 1'b0) begin bad++; $display("FAIL wr_w_clear: got %b want 0", axi_req.w_valid); end
    send_b(3'd0, AXI_RESP_OKAY); #1;
    total++; if (axi_req.b_ready !== 1'b1) begin bad++; $display("FAIL wr_b_ready: got %b want 1", axi_req.b_ready); end
    cyc(); axi_rsp.b_valid = 1'b0;
    total++; if (r_valid !== 1'b1 || r_id !== 5'd5) begin bad++; $display("FAIL wr_resp: got valid=%b id=%0d want 1 5", r_valid, r_id); end
    total++; if (r_opc !== 1'b0 || r_rdata !== 32'h0) begin bad++; $display("FAIL wr_resp_data: got opc=%b rdata=%h want 0 0", r_opc, r_rdata); end
    cyc();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_full_table();
    logic [4:0] exp_ids [4];
    exp_ids = '{5'd10, 5'd11, 5'd14, 5'd13};
    axi_rsp.ar_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b0, 32'h4000_0000 + 32'(8 * i), '0, 4'hf, 5'(10 + i)); #1;
      total++; if (gnt !== 1'b1) begin bad++; $display("FAIL full_gnt%0d: got %b want 1", i, gnt); end
      cyc(); drop_req();
      total++; if (axi_req.ar_valid !== 1'b1 || axi_req.ar.id !== 3'(i)) begin
        bad++; $display("FAIL full_ar_id%0d: got valid=%b id=%0d want 1 %0d", i, axi_req.ar_valid, axi_req.ar.id, i); end
      cyc();
    end
    drive_req(1'b0, 32'h4000_0100, '0, 4'hf, 5'd14); #1;
    total++; if (gnt !== 1'b0) begin bad++; $display("FAIL full_5th_gnt: got %b want 0", gnt); end
    cyc();
    total++; if (gnt !== 1'b0) begin bad++; $display("FAIL full_hold_gnt: got %b want 0", gnt); end
    send_r(3'd2, 64'h0000_0000_5555_0002, AXI_RESP_OKAY); #1;
    total++; if (gnt !== 1'b0) begin bad++; $display("FAIL full_same_cycle_gnt: got %b want 0", gnt); end
    cyc(); axi_rsp.r_valid = 1'b0; #1;
    total++; if (r_valid !== 1'b1 || r_id !== 5'd12 || r_rdata !== 32'h5555_0002) begin
      bad++; $display("FAIL full_r: got valid=%b id=%0d rdata=%h want 1 12 55550002", r_valid, r_id, r_rdata); end
    total++; if (gnt !== 1'b1) begin bad++; $display("FAIL full_freed_gnt: got %b want 1", gnt); end
    cyc(); drop_req();
    total++; if (axi_req.ar_valid !== 1'b1 || axi_req.ar.id !== 3'd2) begin
      bad++; $display("FAIL full_reuse_id: got valid=%b id=%0d want 1 2", axi_req.ar_valid, axi_req.ar.id); end
    cyc();
    send_r(3'd0, 64'h0, AXI_RESP_OKAY);
    cyc();
    for (int k = 1; k < 4; k++) begin
      send_r(3'(k), 64'h0, AXI_RESP_OKAY);
      total++; if (r_valid !== 1'b1 || r_id !== exp_ids[k-1]) begin
        bad++; $display("FAIL b2b_r%0d: got valid=%b id=%0d want 1 %0d", k - 1, r_valid, r_id, exp_ids[k-1]); end
      cyc();
    end
    axi_rsp.r_valid = 1'b0;
    total++; if (r_valid !== 1'b1 || r_id !== exp_ids[3]) begin
      bad++; $display("FAIL b2b_r3: got valid=%b id=%0d want 1 %0d", r_valid, r_id, exp_ids[3]); end
    cyc();
    total++; if (r_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL full_drain: got valid=%b busy=%b want 0 0", r_valid, busy); end
    axi_rsp.ar_ready = 1'b0;
  endtask

  task automatic test_out_of_order();
    axi_rsp.ar_ready = 1'b1;
    drive_req(1'b0, 32'h3000_0000, '0, 4'hf, 5'd7); cyc(); drop_req(); cyc();
    drive_req(1'b0, 32'h3000_0004, '0, 4'hf, 5'd8); cyc(); drop_req(); cyc();
    drive_req(1'b0, 32'h3000_000C, '0, 4'hf, 5'd9); cyc(); drop_req(); cyc();
    axi_rsp.ar_ready = 1'b0;
    send_r(3'd2, 64'hCAFE_0009_0000_0000, AXI_RESP_OKAY);
    cyc();
    send_r(3'd0, 64'hFFFF_FFFF_7777_0007, AXI_RESP_OKAY);
    total++; if (r_valid !== 1'b1 || r_id !== 5'd9 || r_rdata !== 32'hCAFE_0009) begin
      bad++; $display("FAIL ooo_first: got valid=%b id=%0d rdata=%h want 1 9 cafe0009", r_valid, r_id, r_rdata); end
    cyc();
    send_r(3'd1, 64'h0000_0008_0000_0000, AXI_RESP_OKAY);
    total++; if (r_valid !== 1'b1 || r_id !== 5'd7 || r_rdata !== 32'h7777_0007) begin
      bad++; $display("FAIL ooo_second: got valid=%b id=%0d rdata=%h want 1 7 77770007", r_valid, r_id, r_rdata); end
    cyc(); axi_rsp.r_valid = 1'b0;
    total++; if (r_id !== 5'd8 || r_rdata !== 32'h0000_0008) begin
      bad++; $display("FAIL ooo_third: got id=%0d rdata=%h want 8 00000008", r_id, r_rdata); end
    cyc();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ooo_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_r_b_collision();
    axi_rsp.ar_ready = 1'b1; axi_rsp.aw_ready = 1'b1; axi_rsp.w_ready = 1'b1;
    drive_req(1'b0, 32'h5000_0004, '0, 4'hf, 5'd20); cyc();
    drive_req(1'b1, 32'h5000_0000, 32'hAAAA_5555, 4'hf, 5'd21); #1;
    total++; if (gnt !== 1'b1) begin bad++; $display("FAIL col_wr_gnt: got %b want 1", gnt); end
    cyc(); drop_req(); cyc();
    axi_rsp.ar_ready = 1'b0; axi_rsp.aw_ready = 1'b0; axi_rsp.w_ready = 1'b0;
    send_r(3'd0, 64'h0BAD_F00D_0000_0000, AXI_RESP_OKAY);
    send_b(3'd1, AXI_RESP_SLVERR); #1;
    total++; if ({axi_req.r_ready, axi_req.b_ready} !== 2'b10) begin
      bad++; $display("FAIL col_readies: got %b want 10", {axi_req.r_ready, axi_req.b_ready}); end
    cyc(); axi_rsp.r_valid = 1'b0; #1;
    total++; if (r_valid !== 1'b1 || r_id !== 5'd20 || r_rdata !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL col_r_first: got valid=%b id=%0d rdata=%h want 1 20 0badf00d", r_valid, r_id, r_rdata); end
    total++; if (axi_req.b_ready !== 1'b1) begin bad++; $display("FAIL col_b_ready: got %b want 1", axi_req.b_ready); end
    cyc(); axi_rsp.b_valid = 1'b0;
    total++; if (r_valid !== 1'b1 || r_id !== 5'd21 || r_rdata !== 32'h0) begin
      bad++; $display("FAIL col_b_second: got valid=%b id=%0d rdata=%h want 1 21 0", r_valid, r_id, r_rdata); end
    total++; if (r_opc !== SLVERR_OPC) begin bad++; $display("FAIL col_slverr_opc: got %b want %b", r_opc, SLVERR_OPC); end
    cyc();
    total++; if (busy !== 1'b0 || r_opc !== 1'b0) begin bad++; $display("FAIL col_end: got busy=%b opc=%b want 0 0", busy, r_opc); end
  endtask

  task automatic test_reset_mid();
    axi_rsp.ar_ready = 1'b1;
    drive_req(1'b0, 32'h6000_0000, '0, 4'hf, 5'd1); cyc(); drop_req(); cyc();
    drive_req(1'b0, 32'h6000_0008, '0, 4'hf, 5'd2); cyc(); drop_req(); cyc();
    drive_req(1'b1, 32'h6000_0010, 32'h1, 4'hf, 5'd3); cyc(); drop_req();
    total++; if (busy !== 1'b1 || axi_req.aw_valid !== 1'b1) begin
      bad++; $display("FAIL mid_busy_before: got busy=%b aw_valid=%b want 1 1", busy, axi_req.aw_valid); end
    rst_ni = 1'b0; #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    total++; if ({axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid, r_valid, r_opc} !== 5'b0) begin
      bad++; $display("FAIL mid_outputs: got %b want 00000", {axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid, r_valid, r_opc}); end
    cyc(); rst_ni = 1'b1; cyc();
    drive_req(1'b0, 32'h6000_0000, '0, 4'hf, 5'd4); #1;
    total++; if (gnt !== 1'b1) begin bad++; $display("FAIL mid_regrant: got %b want 1", gnt); end
    cyc(); drop_req();
    total++; if (axi_req.ar.id !== 3'd0) begin bad++; $display("FAIL mid_slot0: got %0d want 0", axi_req.ar.id); end
    cyc(); axi_rsp.ar_ready = 1'b0;
    send_r(3'd0, 64'h0000_0000_4444_4444, AXI_RESP_OKAY);
    cyc(); axi_rsp.r_valid = 1'b0;
    total++; if (r_valid !== 1'b1 || r_id !== 5'd4 || r_rdata !== 32'h4444_4444) begin
      bad++; $display("FAIL mid_r: got valid=%b id=%0d rdata=%h want 1 4 44444444", r_valid, r_id, r_rdata); end
    cyc();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy_end: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_full_table();
    test_out_of_order();
    test_r_b_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
